spcpu_decode_alu_unit: RTL and testbench
========================================

Name: spcpu_decode_alu_unit

Overview:
Registered front-end slice of the spcpu core: instruction-group classifier, group-1 field decoder and 8/16-bit ALU, each with a one-cycle registered output stage. The core feeds it the high 16-bit instruction word on instruction fetch and ALU operands during execute. The unit owns no register file or PC.

Parameters:
none (widths fixed: register 8 bits, instruction word 16 bits, flags 4 bits)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr_in  in  16  instruction word (entire 16-bit instr or high half of 32-bit)
instr_valid  in  1  capture instr_in this cycle
alu_oper  in  4  ALU operation code
alu_a_in_hi  in  8  operand A high byte (pair ops only)
alu_a_in_lo  in  8  operand A low byte
alu_b_in  in  8  operand B
alu_flags_in  in  4  current flags {N,V,C,Z} = bits [3:0] = {3,2,1,0}
alu_valid  in  1  capture ALU operands this cycle
group_out  out  3  0=unknown, 1..5=group 1..5
grp_is_32_bit  out  1  group 5 (needs second fetch)
ig1_opcode  out  3  group-1 opcode
ig1_ra_index  out  4  group-1 rA
ig1_imm_value_8  out  8  group-1 immediate
ig1_ra_index_is_for_pair  out  1  rA names a register pair
ig1_alu_oper  out  4  ALU op implied by group-1 opcode
dec_valid  out  1  decode outputs updated last cycle
alu_out_hi  out  8  result high byte
alu_out_lo  out  8  result low byte
alu_flags_out  out  4  resulting flags
alu_out_valid  out  1  ALU outputs updated last cycle

Behaviour:
- Reset (sync, active-high, wins over valids): every output = 0 (group_out=unknown).
- Latency 1 cycle both paths; dec_valid/alu_out_valid = registered instr_valid/alu_valid. Data outputs hold when their valid input is low.
- Group classification of instr_in: [15]=0 → 1; [15:13]=100 → 2; [15:13]=101 → 3; [15:12]=1100 → 4; [15:12]=1101 → 5 (grp_is_32_bit=1); 1110/1111 → 0.
- Group-1 fields, always decoded from instr_in regardless of group: opcode=[14:12], ra=[11:8], imm=[7:0].
  - Opcodes: 0 addi, 1 adci, 2 subi, 3 sbci, 4 cmpi, 5 andi, 6 orri, 7 addpi.
  - ig1_alu_oper: 0,1,2,3,4,5,6,14 respectively.
  - ig1_ra_index_is_for_pair=1 only for opcode 7.
  - When group_out≠1, field outputs are don't-care but deterministic.
- ALU ops: 0 add, 1 adc, 2 sub, 3 sbc, 4 cmp, 5 and, 6 orr, 7 xor, 8 lsl, 9 lsr, 10 asr, 11 rol, 12 ror, 13 cpy, 14 addp, 15 subp.
- 8-bit ops use a_lo and b. out_hi=0 for all 8-bit ops.
- Arithmetic flags:
  - add/adc: C = carry out; adc adds C_in.
  - sub/sbc: C=1 means no borrow; sbc computes a−b−!C_in.
  - cmp: flags as sub; out_lo=a_lo.
  - V = signed overflow; Z = result==0; N = result MSB.
- Logic ops (and/orr/xor): update Z,N; C,V preserved.
- lsl/lsr/asr: shift by 1; C = bit shifted out; Z,N updated; V preserved.
- rol/ror: rotate 9 bits through C.
- cpy: out_lo=b; all flags preserved.
- addp/subp: 16-bit {a_hi,a_lo} ± zero-extended b; result on {out_hi,out_lo}. C/V/Z/N are computed on 16 bits (C=no-borrow for subp).
- Simultaneous instr_valid and alu_valid are independent; both update.

Optional Feature:
ALU_SHIFT_ROTATE_EN: defined → ops 8–12 behave as above. Undefined → ops 8–12 give out_lo=a_lo, out_hi=0, flags=flags_in; all other ops unchanged.

Test Plan:
- instr_in=0x1A05, instr_valid=1 → next cycle group_out=1, opcode=1, ra=0xA, imm=0x05, pair=0, ig1_alu_oper=1, dec_valid=1.
- instr_in=0x7E10 → group 1, opcode=7, ra=0xE, pair=1, ig1_alu_oper=14. instr_in=0xD123 → group 5, grp_is_32_bit=1. instr_in=0xE000 → group_out=0. instr_in=0x8000/0xA000/0xC000 → groups 2/3/4.
- add a_lo=0x7F, b=0x01, flags_in=0 → out_lo=0x80, flags=0b1100. sub 0x10−0x10 → out_lo=0x00, flags=0b0011. sbc 0x00−0x00 with C_in=0 → 0xFF, flags=0b1000.
- addp a=0x12FF, b=0x01 → out=0x1300, flags=0. subp a=0x0000, b=0x01 → 0xFFFF, flags=0b1000.
- lsl 0x81 with flags_in=0 → out_lo=0x02, C=1 (flags=0b0010). Without ALU_SHIFT_ROTATE_EN → out_lo=0x81, flags=0b0000.
- Assert reset with instr_valid=alu_valid=1 and prior nonzero outputs → next cycle all outputs 0. Deassert → normal 1-cycle operation resumes.

Source files
------------

// File: rtl/spcpu_decode_alu_unit.sv
// spcpu_decode_alu_unit: registered front-end slice of the spcpu core.
// Classifies the high 16-bit instruction word into its group and decodes
// group-1 fields. It also runs an 8/16-bit ALU with flags {N,V,C,Z}.
// Each path has a one-cycle registered output stage.
// Optional feature macro: ALU_SHIFT_ROTATE_EN enables ops 8..12 (shifts and
// rotates). Without it those ops pass a_lo through and leave the flags unchanged.
module spcpu_decode_alu_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr_in,
   input  logic        instr_valid,
   input  logic [3:0]  alu_oper,
   input  logic [7:0]  alu_a_in_hi,
   input  logic [7:0]  alu_a_in_lo,
   input  logic [7:0]  alu_b_in,
   input  logic [3:0]  alu_flags_in,
   input  logic        alu_valid,
   output logic [2:0]  group_out,
   output logic        grp_is_32_bit,
   output logic [2:0]  ig1_opcode,
   output logic [3:0]  ig1_ra_index,
   output logic [7:0]  ig1_imm_value_8,
   output logic        ig1_ra_index_is_for_pair,
   output logic [3:0]  ig1_alu_oper,
   output logic        dec_valid,
   output logic [7:0]  alu_out_hi,
   output logic [7:0]  alu_out_lo,
   output logic [3:0]  alu_flags_out,
   output logic        alu_out_valid
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_ADC  = 4'd1,  OP_SUB  = 4'd2,  OP_SBC  = 4'd3,
      OP_CMP  = 4'd4,  OP_AND  = 4'd5,  OP_ORR  = 4'd6,  OP_XOR  = 4'd7,
      OP_LSL  = 4'd8,  OP_LSR  = 4'd9,  OP_ASR  = 4'd10, OP_ROL  = 4'd11,
      OP_ROR  = 4'd12, OP_CPY  = 4'd13, OP_ADDP = 4'd14, OP_SUBP = 4'd15
   } alu_op_e;

   alu_op_e     op;
   logic [2:0]  grp_next;
   logic [3:0]  ig1_alu_next;
   logic [8:0]  sum9;
   logic [16:0] sum17;
   logic [7:0]  res_hi;
   logic [7:0]  res_lo;
   logic        flag_n;
   logic        flag_v;
   logic        flag_c;
   logic        flag_z;
   logic        cin;

   assign op  = alu_op_e'(alu_oper);
   assign cin = alu_flags_in[1];

   // Instruction group from the top opcode bits, plus the ALU op for group 1.
   always_comb begin
      grp_next = 3'd0;
      casez (instr_in[15:12])
         4'b0???: grp_next = 3'd1;
         4'b100?: grp_next = 3'd2;
         4'b101?: grp_next = 3'd3;
         4'b1100: grp_next = 3'd4;
         4'b1101: grp_next = 3'd5;
         default: grp_next = 3'd0;
      endcase
      ig1_alu_next = (instr_in[14:12] == 3'd7) ? 4'd14 : {1'b0, instr_in[14:12]};
   end

   // ALU result and flags. Flags not touched by an op keep their input value.
   always_comb begin
      sum9   = 9'd0;
      sum17  = 17'd0;
      res_hi = 8'd0;
      res_lo = alu_a_in_lo;
      flag_n = alu_flags_in[3];
      flag_v = alu_flags_in[2];
      flag_c = alu_flags_in[1];
      flag_z = alu_flags_in[0];
      case (op)
         OP_ADD, OP_ADC: begin
            sum9   = {1'b0, alu_a_in_lo} + {1'b0, alu_b_in} + {8'd0, (op == OP_ADC) & cin};
            res_lo = sum9[7:0];
            flag_c = sum9[8];
            flag_v = (alu_a_in_lo[7] == alu_b_in[7]) && (sum9[7] != alu_a_in_lo[7]);
            flag_z = (sum9[7:0] == 8'd0);
            flag_n = sum9[7];
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            sum9   = {1'b0, alu_a_in_lo} - {1'b0, alu_b_in} - {8'd0, (op == OP_SBC) & ~cin};
            res_lo = (op == OP_CMP) ? alu_a_in_lo : sum9[7:0];
            flag_c = ~sum9[8];
            flag_v = (alu_a_in_lo[7] != alu_b_in[7]) && (sum9[7] != alu_a_in_lo[7]);
            flag_z = (sum9[7:0] == 8'd0);
            flag_n = sum9[7];
         end
         OP_AND, OP_ORR, OP_XOR: begin
            if (op == OP_AND)
               res_lo = alu_a_in_lo & alu_b_in;
            else if (op == OP_ORR)
               res_lo = alu_a_in_lo | alu_b_in;
            else
               res_lo = alu_a_in_lo ^ alu_b_in;
            flag_z = (res_lo == 8'd0);
            flag_n = res_lo[7];
         end
`ifdef ALU_SHIFT_ROTATE_EN
         OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
            case (op)
               OP_LSL: begin res_lo = {alu_a_in_lo[6:0], 1'b0};             flag_c = alu_a_in_lo[7]; end
               OP_LSR: begin res_lo = {1'b0, alu_a_in_lo[7:1]};             flag_c = alu_a_in_lo[0]; end
               OP_ASR: begin res_lo = {alu_a_in_lo[7], alu_a_in_lo[7:1]};   flag_c = alu_a_in_lo[0]; end
               OP_ROL: begin res_lo = {alu_a_in_lo[6:0], cin};              flag_c = alu_a_in_lo[7]; end
               default: begin res_lo = {cin, alu_a_in_lo[7:1]};             flag_c = alu_a_in_lo[0]; end
            endcase
            flag_z = (res_lo == 8'd0);
            flag_n = res_lo[7];
         end
`endif
         OP_CPY: begin
            res_lo = alu_b_in;
         end
         OP_ADDP, OP_SUBP: begin
            if (op == OP_ADDP) begin
               sum17  = {1'b0, alu_a_in_hi, alu_a_in_lo} + {9'd0, alu_b_in};
               flag_c = sum17[16];
               flag_v = ~alu_a_in_hi[7] & sum17[15];
            end else begin
               sum17  = {1'b0, alu_a_in_hi, alu_a_in_lo} - {9'd0, alu_b_in};
               flag_c = ~sum17[16];
               flag_v = alu_a_in_hi[7] & ~sum17[15];
            end
            res_hi = sum17[15:8];
            res_lo = sum17[7:0];
            flag_z = (sum17[15:0] == 16'd0);
            flag_n = sum17[15];
         end
         default: begin
            res_hi = 8'd0;
            res_lo = alu_a_in_lo;
         end
      endcase
   end

   // Output registers: reset clears everything, otherwise each path loads on its valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         group_out                <= 3'd0;
         grp_is_32_bit            <= 1'b0;
         ig1_opcode               <= 3'd0;
         ig1_ra_index             <= 4'd0;
         ig1_imm_value_8          <= 8'd0;
         ig1_ra_index_is_for_pair <= 1'b0;
         ig1_alu_oper             <= 4'd0;
         dec_valid                <= 1'b0;
         alu_out_hi               <= 8'd0;
         alu_out_lo               <= 8'd0;
         alu_flags_out            <= 4'd0;
         alu_out_valid            <= 1'b0;
      end else begin
         dec_valid     <= instr_valid;
         alu_out_valid <= alu_valid;
         if (instr_valid) begin
            group_out                <= grp_next;
            grp_is_32_bit            <= (grp_next == 3'd5);
            ig1_opcode               <= instr_in[14:12];
            ig1_ra_index             <= instr_in[11:8];
            ig1_imm_value_8          <= instr_in[7:0];
            ig1_ra_index_is_for_pair <= (instr_in[14:12] == 3'd7);
            ig1_alu_oper             <= ig1_alu_next;
         end
         if (alu_valid) begin
            alu_out_hi    <= res_hi;
            alu_out_lo    <= res_lo;
            alu_flags_out <= {flag_n, flag_v, flag_c, flag_z};
         end
      end
   end

endmodule

// File: tb/tb_spcpu_decode_alu_unit.sv
// Testbench for spcpu_decode_alu_unit: a scoreboard of expected decode and
// ALU results, produced by an integer-arithmetic reference model.
module tb_spcpu_decode_alu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic [3:0]  alu_oper;
   logic [7:0]  alu_a_in_hi;
   logic [7:0]  alu_a_in_lo;
   logic [7:0]  alu_b_in;
   logic [3:0]  alu_flags_in;
   logic        alu_valid;
   logic [2:0]  group_out;
   logic        grp_is_32_bit;
   logic [2:0]  ig1_opcode;
   logic [3:0]  ig1_ra_index;
   logic [7:0]  ig1_imm_value_8;
   logic        ig1_ra_index_is_for_pair;
   logic [3:0]  ig1_alu_oper;
   logic        dec_valid;
   logic [7:0]  alu_out_hi;
   logic [7:0]  alu_out_lo;
   logic [3:0]  alu_flags_out;
   logic        alu_out_valid;

   typedef struct packed {
      logic [2:0] grp;
      logic       is32;
      logic [2:0] opc;
      logic [3:0] ra;
      logic [7:0] imm;
      logic       pair;
      logic [3:0] aop;
   } dec_t;

   dec_t         dec_q[$];
   logic [19:0]  alu_q[$];
   dec_t         held_dec;
   logic [19:0]  held_alu;
   bit           pend_dec;
   bit           pend_alu;
   int           total = 0;
   int           bad = 0;

   spcpu_decode_alu_unit dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
      .alu_oper(alu_oper), .alu_a_in_hi(alu_a_in_hi), .alu_a_in_lo(alu_a_in_lo),
      .alu_b_in(alu_b_in), .alu_flags_in(alu_flags_in), .alu_valid(alu_valid),
      .group_out(group_out), .grp_is_32_bit(grp_is_32_bit), .ig1_opcode(ig1_opcode),
      .ig1_ra_index(ig1_ra_index), .ig1_imm_value_8(ig1_imm_value_8),
      .ig1_ra_index_is_for_pair(ig1_ra_index_is_for_pair), .ig1_alu_oper(ig1_alu_oper),
      .dec_valid(dec_valid), .alu_out_hi(alu_out_hi), .alu_out_lo(alu_out_lo),
      .alu_flags_out(alu_flags_out), .alu_out_valid(alu_out_valid)
   );

   always #5 clk = ~clk;

   // Reference decode of one instruction word.
   function automatic dec_t modelDecode(input logic [15:0] w);
      dec_t d;
      if (w[15] == 1'b0)             d.grp = 3'd1;
      else if (w[14:13] == 2'b00)    d.grp = 3'd2;
      else if (w[14:13] == 2'b01)    d.grp = 3'd3;
      else if (w[14:12] == 3'b100)   d.grp = 3'd4;
      else if (w[14:12] == 3'b101)   d.grp = 3'd5;
      else                           d.grp = 3'd0;
      d.is32 = (d.grp == 3'd5);
      d.opc  = w[14:12];
      d.ra   = w[11:8];
      d.imm  = w[7:0];
      d.pair = (w[14:12] == 3'd7);
      d.aop  = (w[14:12] == 3'd7) ? 4'd14 : 4'(w[14:12]);
      return d;
   endfunction

   // Reference ALU in integer arithmetic; returns {hi, lo, N, V, C, Z}.
   function automatic logic [19:0] modelAlu(input logic [3:0] op, input logic [7:0] ahi,
                                            input logic [7:0] alo, input logic [7:0] b,
                                            input logic [3:0] f);
      int ua, ub, sa, sb, r, sr, cin, big, sbig;
      logic [7:0] lo, hi;
      logic n, v, c, z;
      ua = alo; ub = b; sa = $signed(alo); sb = $signed(b); cin = f[1];
      lo = alo; hi = 8'd0; {n, v, c, z} = f;
      case (op)
         4'd0, 4'd1: begin
            r  = ua + ub + ((op == 4'd1) ? cin : 0);
            sr = sa + sb + ((op == 4'd1) ? cin : 0);
            lo = r[7:0]; c = (r > 255); v = (sr > 127) || (sr < -128);
            z = (lo == 8'd0); n = lo[7];
         end
         4'd2, 4'd3, 4'd4: begin
            r  = ua - ub - ((op == 4'd3) ? (1 - cin) : 0);
            sr = sa - sb - ((op == 4'd3) ? (1 - cin) : 0);
            lo = (op == 4'd4) ? alo : r[7:0];
            c = (r >= 0); v = (sr > 127) || (sr < -128);
            z = (r[7:0] == 8'd0); n = r[7];
         end
         4'd5: begin lo = alo & b; z = (lo == 8'd0); n = lo[7]; end
         4'd6: begin lo = alo | b; z = (lo == 8'd0); n = lo[7]; end
         4'd7: begin lo = alo ^ b; z = (lo == 8'd0); n = lo[7]; end
`ifdef ALU_SHIFT_ROTATE_EN
         4'd8:  begin r = ua * 2;       lo = r[7:0]; c = (r > 255);     z = (lo == 8'd0); n = lo[7]; end
         4'd9:  begin r = ua / 2;       lo = r[7:0]; c = (ua % 2 == 1); z = (lo == 8'd0); n = lo[7]; end
         4'd10: begin r = sa >>> 1;     lo = r[7:0]; c = (ua % 2 == 1); z = (lo == 8'd0); n = lo[7]; end
         4'd11: begin r = ua * 2 + cin; lo = r[7:0]; c = (r > 255);     z = (lo == 8'd0); n = lo[7]; end
         4'd12: begin r = ua / 2 + cin * 128; lo = r[7:0]; c = (ua % 2 == 1); z = (lo == 8'd0); n = lo[7]; end
`endif
         4'd13: lo = b;
         4'd14, 4'd15: begin
            sbig = $signed({ahi, alo});
            if (op == 4'd14) begin
               big = ahi * 256 + ua + ub; sbig = sbig + ub; c = (big > 65535);
            end else begin
               big = ahi * 256 + ua - ub; sbig = sbig - ub; c = (big >= 0);
            end
            v  = (sbig > 32767) || (sbig < -32768);
            hi = big[15:8]; lo = big[7:0];
            z  = (big[15:0] == 16'd0); n = big[15];
         end
         default: ;
      endcase
      return {hi, lo, n, v, c, z};
   endfunction

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Compare current DUT outputs against the scoreboard (called at negedge).
   task automatic verifyOutputs();
      checkOutput("dec_valid", 32'(dec_valid), 32'(pend_dec));
      if (pend_dec) begin
         checkOutput("dec_queue", dec_q.size(), 1);
         if (dec_q.size() > 0) held_dec = dec_q.pop_front();
      end
      checkOutput("group", 32'(group_out), 32'(held_dec.grp));
      checkOutput("is32", 32'(grp_is_32_bit), 32'(held_dec.is32));
      checkOutput("opcode", 32'(ig1_opcode), 32'(held_dec.opc));
      checkOutput("ra", 32'(ig1_ra_index), 32'(held_dec.ra));
      checkOutput("imm", 32'(ig1_imm_value_8), 32'(held_dec.imm));
      checkOutput("pair", 32'(ig1_ra_index_is_for_pair), 32'(held_dec.pair));
      checkOutput("ig1_alu", 32'(ig1_alu_oper), 32'(held_dec.aop));
      checkOutput("alu_valid", 32'(alu_out_valid), 32'(pend_alu));
      if (pend_alu) begin
         checkOutput("alu_queue", alu_q.size(), 1);
         if (alu_q.size() > 0) held_alu = alu_q.pop_front();
      end
      checkOutput("alu_hi", 32'(alu_out_hi), 32'(held_alu[19:12]));
      checkOutput("alu_lo", 32'(alu_out_lo), 32'(held_alu[11:4]));
      checkOutput("alu_flags", 32'(alu_flags_out), 32'(held_alu[3:0]));
   endtask

   // One cycle: check last cycle's results, then drive and record new stimulus.
   task automatic applyStimulus(input bit rst, input bit iv, input logic [15:0] w,
                                input bit av, input logic [3:0] op, input logic [7:0] ahi,
                                input logic [7:0] alo, input logic [7:0] b,
                                input logic [3:0] f);
      @(negedge clk);
      verifyOutputs();
      reset = rst; instr_valid = iv; instr_in = w;
      alu_valid = av; alu_oper = op; alu_a_in_hi = ahi; alu_a_in_lo = alo;
      alu_b_in = b; alu_flags_in = f;
      if (rst) begin
         dec_q.delete(); alu_q.delete();
         pend_dec = 1'b0; pend_alu = 1'b0;
         held_dec = '0; held_alu = '0;
      end else begin
         pend_dec = iv; pend_alu = av;
         if (iv) dec_q.push_back(modelDecode(w));
         if (av) alu_q.push_back(modelAlu(op, ahi, alo, b, f));
      end
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr_in = 16'h0; alu_valid = 1'b0;
      alu_oper = 4'h0; alu_a_in_hi = 8'h0; alu_a_in_lo = 8'h0; alu_b_in = 8'h0;
      alu_flags_in = 4'h0;
      pend_dec = 1'b0; pend_alu = 1'b0; held_dec = '0; held_alu = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Directed vectors: decode groups/fields and ALU boundary cases.
      applyStimulus(0, 1, 16'h1A05, 1, 4'd0,  8'h00, 8'h7F, 8'h01, 4'b0000);
      applyStimulus(0, 1, 16'h7E10, 1, 4'd2,  8'h00, 8'h10, 8'h10, 4'b0000);
      applyStimulus(0, 1, 16'hD123, 1, 4'd3,  8'h00, 8'h00, 8'h00, 4'b0000);
      applyStimulus(0, 1, 16'hE000, 1, 4'd14, 8'h12, 8'hFF, 8'h01, 4'b0000);
      applyStimulus(0, 1, 16'h8000, 1, 4'd15, 8'h00, 8'h00, 8'h01, 4'b0000);
      applyStimulus(0, 1, 16'hA000, 1, 4'd8,  8'h00, 8'h81, 8'h00, 4'b0000);
      applyStimulus(0, 1, 16'hC000, 1, 4'd13, 8'h55, 8'h33, 8'hA5, 4'b1111);
      applyStimulus(0, 1, 16'hF0FF, 0, 4'd0,  8'h00, 8'h00, 8'h00, 4'b0000);
      applyStimulus(0, 0, 16'h0000, 1, 4'd4,  8'h00, 8'h05, 8'h09, 4'b0000);
      applyStimulus(0, 0, 16'h1234, 0, 4'd0,  8'hFF, 8'hFF, 8'hFF, 4'b1111);

      // Random traffic with independent valids.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 16'($urandom),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      end

      // Make outputs nonzero, then reset with both valids high.
      applyStimulus(0, 1, 16'h7FFF, 1, 4'd15, 8'h80, 8'h00, 8'h01, 4'b0000);
      applyStimulus(1, 1, 16'h5A5A, 1, 4'd0,  8'h00, 8'h11, 8'h22, 4'b0000);
      applyStimulus(0, 1, 16'h2B7F, 1, 4'd1,  8'h00, 8'hFF, 8'h00, 4'b0010);
      applyStimulus(0, 0, 16'h0000, 0, 4'd0,  8'h00, 8'h00, 8'h00, 4'b0000);
      applyStimulus(0, 0, 16'h0000, 0, 4'd0,  8'h00, 8'h00, 8'h00, 4'b0000);

      checkOutput("dec_q_left", dec_q.size(), 0);
      checkOutput("alu_q_left", alu_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
